spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Single-clock SPI master that drives the SPI slave/RAM block from a parallel command port. It frames each command, shifts the 10-bit word `{op[1:0], data[7:0]}` out on MOSI MSB-first and, for read-data commands, captures the 8-bit RAM byte returned on MISO. It sits between the system bus adapter or the UVM sequence driver and the slave's `ss_n`/`MOSI`/`MISO` pins, in the same clock domain as the slave.

## Interface
Parameters:
- `TURNAROUND`, default 2: idle cycles after the last MOSI bit of a read-data word before the first MISO sample. Legal range 1..15.
- `GAP`, default 1: cycles `ss_n` is held high between frames. Legal range 1..7.

Ports:
- `clk` in 1: sole clock. Every flop updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block is in IDLE and accepts a command.
- `cmd_op` in 2: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- `cmd_data` in 8: address or data byte.
- `rd_data` out 8: captured read byte.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is valid in that cycle.
- `busy` out 1: a frame or the inter-frame gap is in progress.
- `err` out 1: one-cycle pulse, present only when `SPI_MASTER_RD_ORDER_EN` is defined.
- `ss_n` out 1: slave select, active low.
- `MOSI` out 1: serial data to the slave.
- `MISO` in 1: serial data from the slave.

## Operation
- Handshake: a command is accepted on the cycle where `cmd_valid && cmd_ready`. `cmd_op` and `cmd_data` are latched into a 10-bit shift register in that cycle. The inputs are don't-care at all other times.
- FSM states: IDLE, START, CMD, SHIFT, TURN, RECV, GAP.
  - IDLE: `cmd_ready`=1, `ss_n`=1. On accept, go to START.
  - START: `ss_n`=0, `MOSI`=0. Always go to CMD. The slave leaves its idle state here.
  - CMD: `MOSI`=`op[1]` (the slave's command-check bit). Always go to SHIFT.
  - SHIFT: 10 cycles. `MOSI` = shift-register MSB, then shift left. A 4-bit counter runs 0..9.
    - At count 9, op 11 goes to TURN.
    - At count 9, any other op goes to GAP.
  - TURN: `TURNAROUND` cycles with `MOSI`=0 and `ss_n`=0. Then go to RECV.
  - RECV: 8 cycles. Sample `MISO` into `rd_data` MSB-first. After the 8th sample, pulse `rd_valid` for one cycle and go to GAP.
  - GAP: `ss_n`=1 for `GAP` cycles. Then go to IDLE.
- `busy` = (state != IDLE).
- `rd_data` holds its last captured value until the next RECV completes. Partial bits are assembled in a separate shift register, so `rd_data` never shows a partial byte.
- `cmd_valid` asserted outside IDLE is ignored. It is not queued.

## Timing
- Reset values:
  - state = IDLE
  - `ss_n`=1, `MOSI`=0
  - `cmd_ready`=1, `busy`=0
  - `rd_valid`=0, `err`=0
  - `rd_data`=8'h00
  - all counters 0
- All outputs are registered.
- Accept at cycle A gives:
  - `ss_n` falls at A+1.
  - Command bit appears at A+2.
  - Word bits 9..0 appear at A+3..A+12.
- Write-class frame (op 00, 01, 10):
  - `ss_n` rises at A+13.
  - `cmd_ready` returns at A+13+`GAP`.
- Read-data frame (op 11):
  - MISO sampled at A+13+`TURNAROUND` .. A+20+`TURNAROUND`.
  - `rd_valid` at A+21+`TURNAROUND`, together with the `ss_n` rise.
  - `cmd_ready` returns at A+21+`TURNAROUND`+`GAP`.
- A new command can be accepted in the same cycle `cmd_ready` rises.
- Reset mid-frame: `ss_n` goes high immediately (asynchronous). The frame is abandoned, no `rd_valid` is produced, and the FSM returns to IDLE.

## Configuration
- `SPI_MASTER_RD_ORDER_EN` defined:
  - A 1-bit flag is set on an accepted op 10 and cleared on an accepted op 11.
  - An op 11 accepted while the flag is 0 is dropped: no frame is sent and `ss_n` stays 1.
  - The drop pulses `err` for one cycle at A+1, and `cmd_ready` stays 1.
  - The flag resets to 0.
- Not defined:
  - The `err` port and the flag are absent.
  - Every accepted command is framed as given, regardless of order.

## Test plan
- Reset asserted for 3 cycles, then released: `ss_n`=1, `MOSI`=0, `cmd_ready`=1, `rd_data`=00, `rd_valid`=0.
- Write-addr, op 00 with data 8'hA5, accepted at cycle A:
  - `ss_n` low from A+1 to A+12.
  - MOSI is 0 at A+2, then bits 00_1010_0101 at A+3..A+12.
  - `ss_n` high at A+13.
- Read-addr op 10 with data 8'h3C, then read-data op 11, with a MISO model returning 8'hC3 after TURNAROUND=2:
  - `rd_data`=C3.
  - `rd_valid` is a single pulse at A+23.
- Back-to-back commands with `cmd_valid` held high: the second accept happens exactly at A+13+GAP, and `ss_n` is high for exactly GAP cycles.
- `rst` asserted at A+7 during a write-data frame: `ss_n`=1 in the same cycle, no further MOSI activity, `cmd_ready`=1 after release.
- With `SPI_MASTER_RD_ORDER_EN` defined, op 11 issued right after reset:
  - `err` pulses at A+1.
  - `ss_n` never falls.
  - A following op 10 then op 11 completes normally with no `err`.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master framing {op,data} words to the slave/RAM block; optional read-order check via `SPI_MASTER_RD_ORDER_EN
module spi_master_ctrl #(
  parameter int TURNAROUND = 2,  // idle cycles between last MOSI bit and first MISO sample (1..15)
  parameter int GAP        = 1   // cycles ss_n is held high between frames (1..7)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
`ifdef SPI_MASTER_RD_ORDER_EN
  output logic       err,
`endif
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  sr_q, sr_d;
  logic        is_rd_q, is_rd_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        launch;
`ifdef SPI_MASTER_RD_ORDER_EN
  logic        flag_q, flag_d;
  logic        err_q, err_d;
`endif

  // Next-state logic; every output register is computed from the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    is_rd_d    = is_rd_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    launch     = 1'b0;
`ifdef SPI_MASTER_RD_ORDER_EN
    flag_d     = flag_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
`ifdef SPI_MASTER_RD_ORDER_EN
          // A read-data without a preceding read-addr is dropped and flagged
          if (cmd_op == 2'b11 && !flag_q) begin
            err_d = 1'b1;
          end else begin
            if (cmd_op == 2'b10) begin
              flag_d = 1'b1;
            end else if (cmd_op == 2'b11) begin
              flag_d = 1'b0;
            end
            launch = 1'b1;
          end
`else
          launch = 1'b1;
`endif
        end
      end

      ST_START: begin
        state_d = ST_CMD;
      end

      ST_CMD: begin
        // The first word bit is launched on the way into SHIFT, so shift here too
        sr_d    = {sr_q[8:0], 1'b0};
        cnt_d   = 4'd0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        sr_d = {sr_q[8:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = 4'd0;
          state_d = is_rd_q ? ST_TURN : ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_RECV: begin
        // Partial bits stay in rx_q; rd_data only ever sees a complete byte
        rx_d = {rx_q[5:0], MISO};
        if (cnt_q == RECV_LAST) begin
          rd_data_d  = {rx_q, MISO};
          rd_valid_d = 1'b1;
          cnt_d      = 4'd0;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      sr_d    = {cmd_op, cmd_data};
      is_rd_d = (cmd_op == 2'b11);
      cnt_d   = 4'd0;
      state_d = ST_START;
    end

    ss_n_d      = (state_d == ST_IDLE) || (state_d == ST_GAP);
    mosi_d      = ((state_d == ST_CMD) || (state_d == ST_SHIFT)) ? sr_q[9] : 1'b0;
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and registered outputs; reset releases the slave at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      sr_q        <= 10'd0;
      is_rd_q     <= 1'b0;
      rx_q        <= 7'd0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      is_rd_q     <= is_rd_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef SPI_MASTER_RD_ORDER_EN
  // Read-order flag and its error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign ss_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

  localparam int TA = 2;
  localparam int GP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       ss_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_RD_ORDER_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] word_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  spi_master_ctrl #(.TURNAROUND(TA), .GAP(GP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
`ifdef SPI_MASTER_RD_ORDER_EN
    .err       (err),
`endif
    .ss_n      (ss_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for cmd_ready, present a command and step past its accept edge
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic keep);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready_timeout got %b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    word_q.push_back({op, d});
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; MISO = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n_during got %b required 1", ss_n); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n got %b required 1", ss_n); end
    n_checks++;
    if (MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b required 0", MOSI); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); end
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h required 00", rd_data); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b required 0", rd_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy); end
`ifdef SPI_MASTER_RD_ORDER_EN
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b required 0", err); end
`endif
  endtask

  // Write-class frame: issue, then check every cycle from A+1 to A+13+GP
  task automatic frame_write(input logic [1:0] op, input logic [7:0] d);
    logic [9:0] w;
    logic       exp;
    issue(op, d, 1'b0);
    w = word_q.pop_front();
    for (int k = 1; k <= 13 + GP; k++) begin
      exp = (k >= 13);
      n_checks++;
      if (ss_n !== exp) begin n_fail++; $display("FAIL wr_ss_n k=%0d got %b required %b", k, ss_n, exp); end
      exp = 1'b0;
      if (k == 2) exp = w[9];
      else if (k >= 3 && k <= 12) exp = w[12-k];
      n_checks++;
      if (MOSI !== exp) begin n_fail++; $display("FAIL wr_mosi k=%0d got %b required %b", k, MOSI, exp); end
      exp = (k >= 13 + GP);
      n_checks++;
      if (cmd_ready !== exp) begin n_fail++; $display("FAIL wr_cmd_ready k=%0d got %b required %b", k, cmd_ready, exp); end
      n_checks++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_valid k=%0d got %b required 0", k, rd_valid); end
`ifdef SPI_MASTER_RD_ORDER_EN
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err k=%0d got %b required 0", k, err); end
`endif
      if (k < 13 + GP) tick();
    end
  endtask

  // Read-data frame with a MISO model answering miso_byte in the receive window
  task automatic frame_read(input logic [7:0] miso_byte);
    logic [9:0] w;
    logic [7:0] r;
    logic       exp;
    int         last;
    last = 21 + TA + GP;
    issue(2'b11, 8'h96, 1'b0);
    w = word_q.pop_front();
    rd_q.push_back(miso_byte);
    for (int k = 1; k <= last; k++) begin
      MISO = (k >= 13 + TA && k <= 20 + TA) ? miso_byte[20+TA-k] : 1'b0;
      exp = (k > 20 + TA);
      n_checks++;
      if (ss_n !== exp) begin n_fail++; $display("FAIL rd_ss_n k=%0d got %b required %b", k, ss_n, exp); end
      exp = 1'b0;
      if (k == 2) exp = w[9];
      else if (k >= 3 && k <= 12) exp = w[12-k];
      n_checks++;
      if (MOSI !== exp) begin n_fail++; $display("FAIL rd_mosi k=%0d got %b required %b", k, MOSI, exp); end
      exp = (k == 21 + TA);
      n_checks++;
      if (rd_valid !== exp) begin n_fail++; $display("FAIL rd_valid k=%0d got %b required %b", k, rd_valid, exp); end
      if (k == 20 + TA) begin
        n_checks++;
        if (rd_data !== last_rd) begin n_fail++; $display("FAIL rd_data_hold got %h required %h", rd_data, last_rd); end
      end
      if (k == 21 + TA) begin
        r = rd_q.pop_front();
        n_checks++;
        if (rd_data !== r) begin n_fail++; $display("FAIL rd_data got %h required %h", rd_data, r); end
        last_rd = r;
      end
      exp = (k >= last);
      n_checks++;
      if (cmd_ready !== exp) begin n_fail++; $display("FAIL rd_cmd_ready k=%0d got %b required %b", k, cmd_ready, exp); end
`ifdef SPI_MASTER_RD_ORDER_EN
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err k=%0d got %b required 0", k, err); end
`endif
      if (k < last) tick();
    end
    MISO = 1'b0;
  endtask

  task automatic test_write_addr;
    frame_write(2'b00, 8'hA5);
  endtask

  task automatic test_write_data;
    frame_write(2'b01, 8'h5A);
  endtask

  task automatic test_read;
    frame_write(2'b10, 8'h3C);
    frame_read(8'hC3);
    frame_write(2'b10, 8'h0F);
    frame_read(8'h5A);
  endtask

  task automatic test_back_to_back;
    logic [9:0] w1, w2;
    logic       exp;
    int         acc, gap_hi;
    acc = -1;
    gap_hi = 0;
    issue(2'b01, 8'h69, 1'b1);
    w1 = word_q.pop_front();
    cmd_op   = 2'b00;
    cmd_data = 8'hE1;
    word_q.push_back({2'b00, 8'hE1});
    for (int k = 1; k <= 40; k++) begin
      if (k >= 3 && k <= 12) begin
        n_checks++;
        if (MOSI !== w1[12-k]) begin n_fail++; $display("FAIL b2b_mosi1 k=%0d got %b required %b", k, MOSI, w1[12-k]); end
      end
      if (ss_n && busy) gap_hi++;
      if (cmd_ready) begin
        acc = k;
        break;
      end
      tick();
    end
    n_checks++;
    if (acc != 13 + GP) begin n_fail++; $display("FAIL b2b_accept_cycle got %0d required %0d", acc, 13 + GP); end
    n_checks++;
    if (gap_hi != GP) begin n_fail++; $display("FAIL b2b_gap_cycles got %0d required %0d", gap_hi, GP); end
    tick();
    cmd_valid = 1'b0;
    w2 = word_q.pop_front();
    for (int k = 1; k <= 13; k++) begin
      exp = (k >= 13);
      n_checks++;
      if (ss_n !== exp) begin n_fail++; $display("FAIL b2b_ss_n2 k=%0d got %b required %b", k, ss_n, exp); end
      exp = 1'b0;
      if (k == 2) exp = w2[9];
      else if (k >= 3 && k <= 12) exp = w2[12-k];
      n_checks++;
      if (MOSI !== exp) begin n_fail++; $display("FAIL b2b_mosi2 k=%0d got %b required %b", k, MOSI, exp); end
      if (k < 13) tick();
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] w;
    issue(2'b01, 8'hFF, 1'b0);
    w = word_q.pop_front();
    repeat (6) tick();
    n_checks++;
    if (ss_n !== 1'b0) begin n_fail++; $display("FAIL mid_ss_n_before got %b required 0", ss_n); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ss_n !== 1'b1) begin n_fail++; $display("FAIL mid_ss_n_async got %b required 1", ss_n); end
    n_checks++;
    if (MOSI !== 1'b0) begin n_fail++; $display("FAIL mid_mosi_async got %b required 0", MOSI); end
    tick();
    tick();
    rst = 1'b0;
    last_rd = 8'h00;
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (MOSI !== 1'b0 || ss_n !== 1'b1 || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_quiet k=%0d got mosi=%b ss_n=%b rd_valid=%b required 0 1 0", k, MOSI, ss_n, rd_valid);
      end
      tick();
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready got %b required 1 (word %h)", cmd_ready, w); end
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rd_data got %h required 00", rd_data); end
  endtask

`ifdef SPI_MASTER_RD_ORDER_EN
  task automatic test_rd_order;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = 8'h00;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 8'h11;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL order_err_pulse got %b required 1", err); end
    n_checks++;
    if (ss_n !== 1'b1) begin n_fail++; $display("FAIL order_ss_n got %b required 1", ss_n); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL order_cmd_ready got %b required 1", cmd_ready); end
    for (int k = 2; k <= 15; k++) begin
      tick();
      n_checks++;
      if (err !== 1'b0 || ss_n !== 1'b1) begin
        n_fail++;
        $display("FAIL order_quiet k=%0d got err=%b ss_n=%b required 0 1", k, err, ss_n);
      end
    end
    frame_write(2'b10, 8'h3C);
    frame_read(8'hA6);
  endtask
`endif

  initial begin
    test_reset();
`ifdef SPI_MASTER_RD_ORDER_EN
    test_rd_order();
`endif
    test_write_addr();
    test_write_data();
    test_read();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
